output_limit_ctrl: RTL and testbench
====================================

// Module: output_limit_ctrl
// PURPOSE
//  Accounts 8-byte output words queued by the application for the high-speed (HS) USB output path.
//  Grants a bounded burst ("output limit") when the host registers a limit through the vendor-command block.
//  Sits between the VCR block (mode_limit, limit_min, reg_output_limit) and the HS output FIFO read side.
//  Returns output_limit / output_limit_done back to VCR for host readout.
// PARAMETERS
//  CNT_W  16  width of the available-word counter (>=16); grants clamp to 16'hFFFF
// PORTS
//  IFCLK              in   1      sole clock
//  RESET              in   1      synchronous, active-high reset
//  hs_en              in   1      HS I/O enabled
//  mode_limit         in   1      1 = limited (grant) mode, 0 = free-running output
//  limit_min          in   16     minimum available words required to grant
//  reg_output_limit   in   1      1-cycle pulse: host requests a new grant
//  word_in            in   1      pulse: one 8-byte word written into output FIFO
//  word_out           in   1      pulse: HS side consumed one 8-byte word
//  out_enable         out  1      HS side may read a word this cycle
//  output_limit       out  16     size of the current/last grant (words)
//  output_limit_done  out  1      no granted words outstanding
//  err_overflow       out  1      sticky: word_in arrived with avail at max
// BEHAVIOUR
//  Reset (one IFCLK with RESET=1): state IDLE, avail=0, remaining=0, output_limit=0,
//   output_limit_done=1, err_overflow=0, out_enable=0. RESET wins over every other input.
//  Registers: avail[CNT_W] = queued, ungranted words; remaining[16] = granted, unsent words.
//  States: IDLE, SEND. output_limit_done = (state==IDLE), registered.
//  IDLE, reg_output_limit=1, mode_limit=1:
//   - avail>=limit_min and avail>0: grant = min(avail, 16'hFFFF).
//     output_limit <= grant; remaining <= grant; avail <= avail-grant(+word_in); -> SEND.
//     output_limit_done falls the cycle after the pulse.
//   - otherwise: output_limit <= 0; stay IDLE.
//  SEND: reg_output_limit ignored; output_limit held.
//   - word_out && out_enable: remaining-1.
//   - remaining 1->0: -> IDLE, done=1 next cycle.
//  Grant arithmetic uses the pre-update avail; a word_in in the same cycle adds to the post-grant avail.
//  out_enable (combinational from registers):
//   - mode_limit=1: hs_en && state==SEND && remaining!=0.
//   - mode_limit=0: hs_en && avail!=0.
//  mode_limit=0: word_out && out_enable decrements avail; word_in increments avail.
//   - Simultaneous word_in and word_out leaves avail unchanged.
//   - reg_output_limit in this mode sets output_limit <= 0 and does not change state.
//  mode_limit dropping to 0 during SEND: the remaining grant continues to drain
//   (out_enable = hs_en && remaining!=0 until IDLE), then free-running output applies.
//  word_out while out_enable=0: ignored, no counter change.
//  word_in with avail = all-ones: avail holds (saturates), err_overflow <= 1 (sticky until RESET).
//  hs_en=0: out_enable=0; counters and state are preserved; grants are still accepted.
//  Latency: reg_output_limit -> output_limit valid next cycle (VCR samples it on a later data clock).
// TESTING
//  1 Reset then 5 word_in, limit_min=3, reg pulse -> output_limit=5, done=0 next cycle, avail=0.
//  2 2 words queued, limit_min=3, reg pulse -> output_limit=0, done=1, state IDLE, avail=2.
//  3 Grant 4, 4 word_out with hs_en=1 -> out_enable drops after 4th; done=1 next cycle; extra word_out ignored.
//  4 Grant in same cycle as word_in (avail=6) -> output_limit=6, avail=1 afterwards.
//  5 mode_limit=0, simultaneous word_in+word_out for 10 cycles -> avail constant; RESET mid-SEND -> all reset values.
//  6 avail forced to all-ones, word_in -> avail unchanged, err_overflow=1 and stays 1 until RESET.

Source files
------------

// File: rtl/output_limit_ctrl.sv
// output_limit_ctrl: tracks the 8-byte words queued for the HS output path.
// In limited mode it grants the host a bounded burst of those words; in free
// mode it lets the HS side drain the queue directly. The grant size and a
// done flag are returned to the vendor-command block for host readout.
module output_limit_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic        IFCLK,
    input  logic        RESET,
    input  logic        hs_en,
    input  logic        mode_limit,
    input  logic [15:0] limit_min,
    input  logic        reg_output_limit,
    input  logic        word_in,
    input  logic        word_out,
    output logic        out_enable,
    output logic [15:0] output_limit,
    output logic        output_limit_done,
    output logic        err_overflow
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    localparam logic [CNT_W-1:0] GRANT_MAX = CNT_W'(16'hFFFF);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_avail;
    logic [15:0]      r_remaining;
    logic [15:0]      r_output_limit;
    logic             r_err_overflow;

    logic             w_send;
    logic             w_out_enable;
    logic             w_take;
    logic [15:0]      w_grant;
    logic             w_grant_ok;
    logic [CNT_W-1:0] w_avail_base;
    logic [CNT_W-1:0] w_avail_next;
    logic             w_overflow;

    // Output gating: a pending grant drains first whatever the mode; with no
    // grant outstanding, free mode serves straight from the queue.
    always_comb begin
        w_send       = (r_state == S_SEND);
        w_out_enable = 1'b0;
        if (hs_en) begin
            if (w_send)
                w_out_enable = (r_remaining != 16'd0);
            else
                w_out_enable = !mode_limit && (r_avail != '0);
        end
        w_take = word_out && w_out_enable;
    end

    // Grant decision and next queue count. The grant uses the pre-update count;
    // a word arriving in the same cycle lands on the post-grant count.
    always_comb begin
        w_grant      = (r_avail > GRANT_MAX) ? 16'hFFFF : r_avail[15:0];
        w_grant_ok   = !w_send && reg_output_limit && mode_limit &&
                       (r_avail >= CNT_W'(limit_min)) && (r_avail != '0);
        w_avail_base = r_avail;
        if (w_grant_ok)
            w_avail_base = r_avail - CNT_W'(w_grant);
        else if (!w_send && !mode_limit && w_take)
            w_avail_base = r_avail - CNT_W'(1);
        w_overflow   = word_in && (&w_avail_base);
        w_avail_next = w_avail_base;
        if (word_in && !(&w_avail_base))
            w_avail_next = w_avail_base + CNT_W'(1);
    end

    // State, counters and host-visible registers.
    always_ff @(posedge IFCLK) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples the pre-edge values computed by the combinational blocks.
        if (RESET) begin
            r_state        <= S_IDLE;
            r_avail        <= '0;
            r_remaining    <= 16'd0;
            r_output_limit <= 16'd0;
            r_err_overflow <= 1'b0;
        end else begin
            r_avail <= w_avail_next;
            if (w_overflow)
                r_err_overflow <= 1'b1;

            if (w_grant_ok) begin
                r_state        <= S_SEND;
                r_remaining    <= w_grant;
                r_output_limit <= w_grant;
            end else if (!w_send && reg_output_limit) begin
                // Refused grant, or a request made in free mode.
                r_output_limit <= 16'd0;
            end

            if (w_send && w_take) begin
                r_remaining <= r_remaining - 16'd1;
                if (r_remaining == 16'd1)
                    r_state <= S_IDLE;
            end
        end
    end

    assign out_enable        = w_out_enable;
    assign output_limit      = r_output_limit;
    assign output_limit_done = (r_state == S_IDLE);
    assign err_overflow      = r_err_overflow;

endmodule

// File: tb/tb_output_limit_ctrl.sv
// Directed bench for output_limit_ctrl: a vector table of per-cycle inputs
// with expected outputs after the edge, plus a hand-written overflow sequence.
module tb_output_limit_ctrl;

    logic        IFCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        hs_en = 1'b0;
    logic        mode_limit = 1'b0;
    logic [15:0] limit_min = 16'd0;
    logic        reg_output_limit = 1'b0;
    logic        word_in = 1'b0;
    logic        word_out = 1'b0;
    logic        out_enable;
    logic [15:0] output_limit;
    logic        output_limit_done;
    logic        err_overflow;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        hs;
        logic        ml;
        logic [15:0] lm;
        logic        rg;
        logic        wi;
        logic        wo;
        logic        e_oe;
        logic [15:0] e_ol;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    output_limit_ctrl #(.CNT_W(16)) dut (
        .IFCLK             (IFCLK),
        .RESET             (RESET),
        .hs_en             (hs_en),
        .mode_limit        (mode_limit),
        .limit_min         (limit_min),
        .reg_output_limit  (reg_output_limit),
        .word_in           (word_in),
        .word_out          (word_out),
        .out_enable        (out_enable),
        .output_limit      (output_limit),
        .output_limit_done (output_limit_done),
        .err_overflow      (err_overflow)
    );

    always #5 IFCLK = ~IFCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic hs, input logic ml, input logic [15:0] lm,
                       input logic rg, input logic wi, input logic wo,
                       input logic e_oe, input logic [15:0] e_ol, input logic e_done,
                       input logic e_err, input int reps);
        vec_t v;
        v.rst = rst; v.hs = hs; v.ml = ml; v.lm = lm; v.rg = rg; v.wi = wi; v.wo = wo;
        v.e_oe = e_oe; v.e_ol = e_ol; v.e_done = e_done; v.e_err = e_err;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic hs, input logic ml, input logic [15:0] lm,
                         input logic rg, input logic wi, input logic wo);
        RESET = rst; hs_en = hs; mode_limit = ml; limit_min = lm;
        reg_output_limit = rg; word_in = wi; word_out = wo;
        @(posedge IFCLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic e_oe, input logic [15:0] e_ol,
                             input logic e_done, input logic e_err);
        check({tag, " out_enable"}, 32'(out_enable), 32'(e_oe));
        check({tag, " output_limit"}, 32'(output_limit), 32'(e_ol));
        check({tag, " done"}, 32'(output_limit_done), 32'(e_done));
        check({tag, " err_overflow"}, 32'(err_overflow), 32'(e_err));
    endtask

    initial begin
        //   rst hs ml lm   rg wi wo | oe ol dn er | reps
        // Reset state.
        add(1, 0, 0, 16'd0, 0, 0, 0,  0, 16'd0, 1, 0, 1);
        // Five words, limit 3, grant 5 then drain; extra word_out ignored.
        add(0, 1, 1, 16'd3, 0, 1, 0,  0, 16'd0, 1, 0, 5);
        add(0, 1, 1, 16'd3, 1, 0, 0,  1, 16'd5, 0, 0, 1);
        add(0, 1, 1, 16'd3, 0, 0, 1,  1, 16'd5, 0, 0, 4);
        add(0, 1, 1, 16'd3, 0, 0, 1,  0, 16'd5, 1, 0, 2);
        // Queue empty after that grant: nothing granted even with limit 0.
        add(0, 1, 1, 16'd0, 1, 0, 0,  0, 16'd0, 1, 0, 1);
        // Two words, limit 3 refused; limit 2 (equal) granted.
        add(0, 1, 1, 16'd3, 0, 1, 0,  0, 16'd0, 1, 0, 2);
        add(0, 1, 1, 16'd3, 1, 0, 0,  0, 16'd0, 1, 0, 1);
        add(0, 1, 1, 16'd2, 1, 0, 0,  1, 16'd2, 0, 0, 1);
        add(0, 1, 1, 16'd2, 0, 0, 1,  1, 16'd2, 0, 0, 1);
        add(0, 1, 1, 16'd2, 0, 0, 1,  0, 16'd2, 1, 0, 1);
        // Grant 4 while hs_en=0: gated, word_out ignored; then drain 4.
        add(0, 0, 1, 16'd1, 0, 1, 0,  0, 16'd2, 1, 0, 4);
        add(0, 0, 1, 16'd1, 1, 0, 0,  0, 16'd4, 0, 0, 1);
        add(0, 0, 1, 16'd1, 0, 0, 1,  0, 16'd4, 0, 0, 1);
        add(0, 1, 1, 16'd1, 0, 0, 0,  1, 16'd4, 0, 0, 1);
        add(0, 1, 1, 16'd1, 0, 0, 1,  1, 16'd4, 0, 0, 3);
        add(0, 1, 1, 16'd1, 0, 0, 1,  0, 16'd4, 1, 0, 2);
        // Grant of 6 in the same cycle as a word_in; request ignored in SEND.
        add(0, 1, 1, 16'd6, 0, 1, 0,  0, 16'd4, 1, 0, 6);
        add(0, 1, 1, 16'd6, 1, 1, 0,  1, 16'd6, 0, 0, 1);
        add(0, 1, 1, 16'd6, 0, 0, 1,  1, 16'd6, 0, 0, 2);
        add(0, 1, 1, 16'd0, 1, 0, 1,  1, 16'd6, 0, 0, 1);
        add(0, 1, 1, 16'd6, 0, 0, 1,  1, 16'd6, 0, 0, 2);
        add(0, 1, 1, 16'd6, 0, 0, 1,  0, 16'd6, 1, 0, 1);
        // The same-cycle word remains queued: a grant of exactly 1.
        add(0, 1, 1, 16'd0, 1, 0, 0,  1, 16'd1, 0, 0, 1);
        add(0, 1, 1, 16'd0, 0, 0, 1,  0, 16'd1, 1, 0, 1);
        // Free mode: one word, ten simultaneous in/out cycles, request clears limit.
        add(0, 1, 0, 16'd0, 0, 0, 0,  0, 16'd1, 1, 0, 1);
        add(0, 1, 0, 16'd0, 0, 1, 0,  1, 16'd1, 1, 0, 1);
        add(0, 1, 0, 16'd0, 0, 1, 1,  1, 16'd1, 1, 0, 10);
        add(0, 1, 0, 16'd0, 1, 0, 0,  1, 16'd0, 1, 0, 1);
        add(0, 1, 0, 16'd0, 0, 0, 1,  0, 16'd0, 1, 0, 2);
        // Grant 3, then mode drops: grant drains first, then free output.
        add(0, 1, 1, 16'd1, 0, 1, 0,  0, 16'd0, 1, 0, 3);
        add(0, 1, 1, 16'd1, 1, 0, 0,  1, 16'd3, 0, 0, 1);
        add(0, 1, 0, 16'd1, 0, 1, 0,  1, 16'd3, 0, 0, 1);
        add(0, 1, 0, 16'd1, 0, 0, 1,  1, 16'd3, 0, 0, 2);
        add(0, 1, 0, 16'd1, 0, 0, 1,  1, 16'd3, 1, 0, 1);
        add(0, 1, 0, 16'd1, 0, 0, 1,  0, 16'd3, 1, 0, 1);
        // RESET in the middle of a grant wins over concurrent inputs.
        add(0, 1, 1, 16'd1, 0, 1, 0,  0, 16'd3, 1, 0, 2);
        add(0, 1, 1, 16'd1, 1, 0, 0,  1, 16'd2, 0, 0, 1);
        add(1, 1, 1, 16'd1, 1, 1, 1,  0, 16'd0, 1, 0, 1);
        add(0, 1, 1, 16'd0, 1, 0, 0,  0, 16'd0, 1, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].hs, vecs[i].ml, vecs[i].lm,
                  vecs[i].rg, vecs[i].wi, vecs[i].wo);
            check_all($sformatf("v%0d", i), vecs[i].e_oe, vecs[i].e_ol,
                      vecs[i].e_done, vecs[i].e_err);
        end

        // Overflow: fill the queue to all-ones with output gated off.
        for (int i = 0; i < 65535; i++)
            drive(0, 0, 1, 16'd0, 0, 1, 0);
        check_all("full", 1'b0, 16'd0, 1'b1, 1'b0);
        drive(0, 0, 1, 16'd0, 0, 1, 0);
        check_all("ovf", 1'b0, 16'd0, 1'b1, 1'b1);
        drive(0, 0, 1, 16'd0, 0, 0, 0);
        check_all("ovf sticky", 1'b0, 16'd0, 1'b1, 1'b1);
        // Saturated count is still all-ones: full-size grant at the top limit.
        drive(0, 0, 1, 16'hFFFF, 1, 0, 0);
        check_all("max grant", 1'b0, 16'hFFFF, 1'b0, 1'b1);
        drive(0, 1, 1, 16'hFFFF, 0, 0, 0);
        check_all("max grant hs", 1'b1, 16'hFFFF, 1'b0, 1'b1);
        drive(1, 0, 0, 16'd0, 0, 0, 0);
        check_all("ovf reset", 1'b0, 16'd0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
